// File: rtl/rgb_palette_fader.sv
// Palette-mapped RGB output that ramps each channel toward its target by STEP per clock.
// Optional macro RGB_FADER_BLANK_EN: enable=0 fades the output to black instead of freezing it.
module rgb_palette_fader #(
  parameter int CH_W  = 8,
  parameter int IDX_W = 3,
  parameter int STEP  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [IDX_W-1:0]    colour,
  input  logic                pal_we,
  input  logic [IDX_W-1:0]    pal_waddr,
  input  logic [3*CH_W-1:0]   pal_wdata,
  output logic [3*CH_W-1:0]   rgb,
  output logic                busy,
  output logic                done
);

  localparam int DEPTH = 2**IDX_W;
  localparam int RGB_W = 3*CH_W;
  // Steps larger than full scale behave exactly like full scale, which keeps the sum inside CH_W+1 bits.
  localparam logic [CH_W:0] STEP_C = (STEP >= 2**CH_W - 1) ? (CH_W+1)'(2**CH_W - 1)
                                                            : (CH_W+1)'(STEP);

  logic [RGB_W-1:0] palette [DEPTH];
  logic [RGB_W-1:0] target;
  logic [RGB_W-1:0] target_n;
  logic [RGB_W-1:0] rgb_n;

  function automatic logic [RGB_W-1:0] def_entry(input int i);
    logic [2:0] b;
    b = 3'(i);
    return {{CH_W{b[2]}}, {CH_W{b[1]}}, {CH_W{b[0]}}};
  endfunction

  function automatic logic [CH_W-1:0] ramp(input logic [CH_W-1:0] cur, input logic [CH_W-1:0] tgt);
    logic [CH_W:0] c;
    logic [CH_W:0] t;
    logic [CH_W:0] nxt;
    c   = {1'b0, cur};
    t   = {1'b0, tgt};
    nxt = c;
    if (c < t) begin
      nxt = c + STEP_C;
      if (nxt > t) nxt = t;
    end else if (c > t) begin
      nxt = ((c - t) > STEP_C) ? (c - STEP_C) : t;
    end
    return nxt[CH_W-1:0];
  endfunction

  always_comb begin
    target_n = target;
`ifdef RGB_FADER_BLANK_EN
    target_n = enable ? palette[colour] : '0;
`else
    if (enable) target_n = palette[colour];
`endif
  end

  // rgb moves toward the target held before this edge, giving one cycle of lookup latency.
  always_comb begin
    rgb_n = rgb;
    for (int ch = 0; ch < 3; ch++) begin
      rgb_n[ch*CH_W +: CH_W] = ramp(rgb[ch*CH_W +: CH_W], target[ch*CH_W +: CH_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) palette[i] <= def_entry(i);
      target <= '0;
      rgb    <= '0;
      done   <= 1'b0;
    end else begin
      if (pal_we) palette[pal_waddr] <= pal_wdata;
      target <= target_n;
      rgb    <= rgb_n;
      done   <= (rgb != target) && (rgb_n == target_n);
    end
  end

  assign busy = (rgb != target);

endmodule

// File: tb/tb_rgb_palette_fader.sv
// Directed bench for rgb_palette_fader: full-step instance (a), STEP=16 instance (b),
// and under RGB_FADER_BLANK_EN a STEP=64 instance (c) for the fade-to-black case.
module tb_rgb_palette_fader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  colour;
  logic        pal_we;
  logic [2:0]  pal_waddr;
  logic [23:0] pal_wdata;
  logic [23:0] rgb_a, rgb_b;
  logic        busy_a, busy_b, done_a, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rgb_palette_fader #(.CH_W(8), .IDX_W(3), .STEP(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .colour(colour), .pal_we(pal_we),
    .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .rgb(rgb_a), .busy(busy_a), .done(done_a));

  rgb_palette_fader #(.CH_W(8), .IDX_W(3), .STEP(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .colour(colour), .pal_we(pal_we),
    .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .rgb(rgb_b), .busy(busy_b), .done(done_b));

`ifdef RGB_FADER_BLANK_EN
  logic [23:0] rgb_c;
  logic        busy_c, done_c;
  rgb_palette_fader #(.CH_W(8), .IDX_W(3), .STEP(64)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .colour(colour), .pal_we(pal_we),
    .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .rgb(rgb_c), .busy(busy_c), .done(done_c));
`endif

  typedef struct {
    logic [2:0]  col;
    logic [23:0] exp_rgb;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [23:0] defp(input int i);
    logic [2:0] b;
    b = 3'(i);
    return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; colour = 3'd0;
    pal_we = 1'b0; pal_waddr = 3'd0; pal_wdata = 24'h0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] t3 [6];
    logic [23:0] prev;
    logic [23:0] ret_exp [4];
    int dones;

    t3 = '{24'h101010, 24'h122020, 24'h123030, 24'h123440, 24'h123450, 24'h123456};
    ret_exp = '{24'h000030, 24'h000020, 24'h000010, 24'h000000};
    for (int c = 0; c < 8; c++) begin
      prev = (c == 0) ? 24'h0 : defp(c - 1);
      vecs[2*c].col       = 3'(c);
      vecs[2*c].exp_rgb   = prev;
      vecs[2*c].exp_busy  = (prev != defp(c));
      vecs[2*c].exp_done  = 1'b0;
      vecs[2*c+1].col      = 3'(c);
      vecs[2*c+1].exp_rgb  = defp(c);
      vecs[2*c+1].exp_busy = 1'b0;
      vecs[2*c+1].exp_done = (prev != defp(c));
    end

    // Reset state
    rst_n = 1'b0; enable = 1'b0; colour = 3'd0;
    pal_we = 1'b0; pal_waddr = 3'd0; pal_wdata = 24'h0;
    tick(); tick();
    chk("reset_rgb", rgb_a, 24'h0);
    chk("reset_busy", 24'(busy_a), 24'h0);
    chk("reset_done", 24'(done_a), 24'h0);
    rst_n = 1'b1;

    // Default palette walk at full step
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      colour = vecs[i].col;
      tick();
      chk($sformatf("walk_rgb[%0d]", i), rgb_a, vecs[i].exp_rgb);
      chk($sformatf("walk_busy[%0d]", i), 24'(busy_a), 24'(vecs[i].exp_busy));
      chk($sformatf("walk_done[%0d]", i), 24'(done_a), 24'(vecs[i].exp_done));
    end

    // STEP=16 ramp of blue from black with saturation on the last step
    do_reset();
    enable = 1'b1; colour = 3'd0;
    tick();
    colour = 3'd1;
    tick();
    chk("ramp_e0_rgb", rgb_b, 24'h0);
    chk("ramp_e0_busy", 24'(busy_b), 24'h1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("ramp_rgb[%0d]", i), rgb_b, (i == 16) ? 24'h0000FF : 24'(16 * i));
      chk($sformatf("ramp_busy[%0d]", i), 24'(busy_b), (i == 16) ? 24'h0 : 24'h1);
      chk($sformatf("ramp_done[%0d]", i), 24'(done_b), (i == 16) ? 24'h1 : 24'h0);
    end
    tick();
    chk("ramp_done_width", 24'(done_b), 24'h0);

    // Palette write then ramp to the written value
    do_reset();
    pal_we = 1'b1; pal_waddr = 3'd2; pal_wdata = 24'h123456;
    tick();
    pal_we = 1'b0; enable = 1'b1; colour = 3'd2;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("pw_rgb[%0d]", i), rgb_b, t3[i]);
      chk($sformatf("pw_done[%0d]", i), 24'(done_b), (i == 5) ? 24'h1 : 24'h0);
    end

    // Same-edge write and lookup of one address returns the old entry first
    do_reset();
    enable = 1'b1; colour = 3'd4;
    pal_we = 1'b1; pal_waddr = 3'd4; pal_wdata = 24'h0A0B0C;
    tick();
    pal_we = 1'b0;
    chk("rbw_e0_rgb", rgb_a, 24'h0);
    tick();
    chk("rbw_e1_rgb", rgb_a, 24'hFF0000);
    chk("rbw_e1_busy", 24'(busy_a), 24'h1);
    chk("rbw_e1_done", 24'(done_a), 24'h0);
    tick();
    chk("rbw_e2_rgb", rgb_a, 24'h0A0B0C);
    chk("rbw_e2_done", 24'(done_a), 24'h1);

    // Retarget mid-ramp: one done pulse only, for the final target
    do_reset();
    enable = 1'b1; colour = 3'd1;
    dones = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      dones += int'(done_b);
    end
    chk("ret_e3_rgb", rgb_b, 24'h000030);
    colour = 3'd0;
    tick();
    dones += int'(done_b);
    chk("ret_e4_rgb", rgb_b, 24'h000040);
    for (int i = 0; i < 4; i++) begin
      tick();
      dones += int'(done_b);
      chk($sformatf("ret_fall[%0d]", i), rgb_b, ret_exp[i]);
    end
    tick(); dones += int'(done_b);
    tick(); dones += int'(done_b);
    chk("ret_done_count", 24'(dones), 24'h1);

    // Asynchronous reset mid-ramp also restores the palette
    do_reset();
    enable = 1'b1; colour = 3'd7;
    pal_we = 1'b1; pal_waddr = 3'd3; pal_wdata = 24'h111111;
    tick();
    pal_we = 1'b0;
    tick(); tick();
    chk("rst_mid_busy_before", 24'(busy_b), 24'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rgb", rgb_b, 24'h0);
    chk("rst_mid_busy", 24'(busy_b), 24'h0);
    chk("rst_mid_done", 24'(done_b), 24'h0);
    tick();
    chk("rst_mid_done_held", 24'(done_b), 24'h0);
    rst_n = 1'b1; colour = 3'd3;
    tick(); tick();
    chk("rst_pal_default", rgb_a, 24'h00FFFF);
    chk("rst_pal_done", 24'(done_a), 24'h1);

`ifndef RGB_FADER_BLANK_EN
    // enable dropped mid-ramp: ramp completes toward the frozen target
    do_reset();
    enable = 1'b1; colour = 3'd1;
    tick(); tick(); tick();
    enable = 1'b0; colour = 3'd6;
    for (int i = 3; i <= 16; i++) tick();
    chk("frz_rgb", rgb_b, 24'h0000FF);
    chk("frz_done", 24'(done_b), 24'h1);
    tick();
    chk("frz_hold_rgb", rgb_b, 24'h0000FF);
    chk("frz_hold_busy", 24'(busy_b), 24'h0);
`else
    // enable dropped at white: fade to black at STEP=64
    do_reset();
    enable = 1'b1; colour = 3'd7;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("blank_white", rgb_c, 24'hFFFFFF);
    chk("blank_white_done", 24'(done_c), 24'h1);
    enable = 1'b0;
    tick();
    chk("blank_e5_rgb", rgb_c, 24'hFFFFFF);
    chk("blank_e5_busy", 24'(busy_c), 24'h1);
    tick();
    chk("blank_bf", rgb_c, 24'hBFBFBF);
    chk("blank_bf_done", 24'(done_c), 24'h0);
    tick();
    chk("blank_7f", rgb_c, 24'h7F7F7F);
    tick();
    chk("blank_3f", rgb_c, 24'h3F3F3F);
    tick();
    chk("blank_00", rgb_c, 24'h000000);
    chk("blank_00_done", 24'(done_c), 24'h1);
    enable = 1'b1;
    tick();
    chk("blank_resume_busy", 24'(busy_c), 24'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
